// File: rtl/reg_readout_tx.sv
// Debug readout transmitter: snapshots a 32-bit register on ctrl_start and shifts it
// out as NUM_BYTES consecutive 8N1 characters, least-significant byte first.
module reg_readout_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        ctrl_start,
    input  logic [31:0] data_in,
    output logic        ctrl_busy,
    output logic        ctrl_done,
    output logic        serial_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [1:0]       byte_idx_reg;
    logic [31:0]      shadow_reg;
    logic [31:0]      capture_word;
    logic             baud_tick;

    // Bytes beyond NUM_BYTES are never transmitted, so they are captured as zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_capture
            if (gi < NUM_BYTES) begin : g_used
                assign capture_word[8*gi +: 8] = data_in[8*gi +: 8];
            end else begin : g_unused
                assign capture_word[8*gi +: 8] = 8'h00;
            end
        end
    endgenerate

    assign baud_tick = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shadow_reg   <= '0;
            ctrl_busy    <= 1'b0;
            ctrl_done    <= 1'b0;
            serial_out   <= 1'b1;
        end else begin
            ctrl_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    serial_out <= 1'b1;
                    ctrl_busy  <= 1'b0;
                    if (ctrl_start) begin
                        shadow_reg   <= capture_word;
                        byte_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        baud_cnt_reg <= '0;
                        state_reg    <= START_BIT;
                        serial_out   <= 1'b0;
                        ctrl_busy    <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA_BITS;
                        serial_out   <= shadow_reg[{byte_idx_reg, 3'd0}];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg  <= STOP_BIT;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            serial_out  <= shadow_reg[{byte_idx_reg, bit_idx_reg + 3'd1}];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg != LAST_BYTE) begin
                            // Next character follows immediately, no idle gap.
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            state_reg    <= START_BIT;
                            serial_out   <= 1'b0;
                        end else begin
                            byte_idx_reg <= '0;
                            state_reg    <= IDLE;
                            ctrl_busy    <= 1'b0;
                            ctrl_done    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    serial_out <= 1'b1;
                    ctrl_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readout_tx.sv
// Scoreboard bench for reg_readout_tx: stimulus queues expected bytes, a line
// decoder pops and compares them, and a busy/done monitor checks frame timing.
module tb_reg_readout_tx;

    localparam int CPB = 4;
    localparam int NB  = 4;

    logic        clock      = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_in    = 32'h0;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        serial_out;

    reg_readout_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .ctrl_start (ctrl_start),
        .data_in    (data_in),
        .ctrl_busy  (ctrl_busy),
        .ctrl_done  (ctrl_done),
        .serial_out (serial_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Line decoder: samples mid-bit, pops the scoreboard on each stop bit.
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic       rx_prev   = 1'b1;
    logic [7:0] rx_byte   = 8'h0;

    always @(negedge clock) begin
        if (ctrl_reset) begin
            rx_active = 1'b0;
            rx_prev   = 1'b1;
        end else begin
            if (!rx_active) begin
                if (rx_prev === 1'b1 && serial_out === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == CPB/2) begin
                    check("start_bit", {63'h0, serial_out}, 64'h0);
                end else if (rx_cnt > CPB/2 && rx_cnt < CPB/2 + 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0) begin
                    rx_byte[(rx_cnt - CPB/2)/CPB - 1] = serial_out;
                end else if (rx_cnt == CPB/2 + 9*CPB) begin
                    check("stop_bit", {63'h0, serial_out}, 64'h1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_byte: got %02h want none (unexpected byte)", rx_byte);
                    end else begin
                        check("rx_byte", {56'h0, rx_byte}, {56'h0, exp_q.pop_front()});
                    end
                    rx_active = 1'b0;
                end
            end
            rx_prev = serial_out;
        end
    end

    // Busy/done monitor.
    int   cyc      = 0;
    int   busy_run = 0;
    int   idle_run = 0;
    int   last_gap = 0;
    int   frames   = 0;
    int   dones    = 0;
    int   done_cyc[$];
    logic pbusy    = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (ctrl_reset) begin
            busy_run = 0;
            idle_run = 0;
            pbusy    = 1'b0;
        end else begin
            if (ctrl_busy === 1'b1) begin
                if (!pbusy) begin
                    frames++;
                    last_gap = idle_run;
                end
                busy_run++;
                idle_run = 0;
            end else begin
                if (pbusy) begin
                    check("busy_len", 64'(busy_run), 64'(NB*10*CPB));
                    check("done_at_fall", {63'h0, ctrl_done}, 64'h1);
                    busy_run = 0;
                end
                idle_run++;
            end
            if (ctrl_done === 1'b1) begin
                dones++;
                done_cyc.push_back(cyc);
                check("done_only_at_fall", {63'h0, (pbusy && ctrl_busy === 1'b0)}, 64'h1);
            end
            pbusy = (ctrl_busy === 1'b1);
        end
    end

    task automatic push_frame(input logic [31:0] d);
        for (int i = 0; i < NB; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic pulse_start(input logic [31:0] d, input logic [31:0] d_after);
        @(posedge clock);
        #1 data_in = d;
        ctrl_start = 1'b1;
        @(posedge clock);
        #1 ctrl_start = 1'b0;
        data_in = d_after;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (ctrl_busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (ctrl_busy !== 1'b0) check(name, {63'h0, ctrl_busy}, 64'h0);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, n;
        bit idle_ok;

        // Asynchronous reset between edges
        @(posedge clock);
        #3 ctrl_reset = 1'b1;
        #1;
        check("rst_serial", {63'h0, serial_out}, 64'h1);
        check("rst_busy",   {63'h0, ctrl_busy},  64'h0);
        check("rst_done",   {63'h0, ctrl_done},  64'h0);
        repeat (2) @(posedge clock);
        #1 ctrl_reset = 1'b0;
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (serial_out !== 1'b1 || ctrl_busy !== 1'b0 || ctrl_done !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_20", {63'h0, idle_ok}, 64'h1);

        // Single frame
        d0 = dones; f0 = frames;
        push_frame(32'hA5C3_0F81);
        pulse_start(32'hA5C3_0F81, 32'h0);
        wait_idle("single_timeout", 400);
        check("single_dones",  64'(dones - d0),  64'd1);
        check("single_frames", 64'(frames - f0), 64'd1);
        check("single_q_empty", 64'(exp_q.size()), 64'd0);

        // Capture isolation
        d0 = dones; f0 = frames;
        push_frame(32'h0000_00FF);
        pulse_start(32'h0000_00FF, 32'hFFFF_FFFF);
        wait_idle("iso_timeout", 400);
        check("iso_dones", 64'(dones - d0), 64'd1);
        check("iso_q_empty", 64'(exp_q.size()), 64'd0);

        // Start while busy
        d0 = dones; f0 = frames;
        push_frame(32'h3C96_E17B);
        pulse_start(32'h3C96_E17B, 32'h5555_AAAA);
        repeat (49) @(posedge clock);
        #1 ctrl_start = 1'b1;
        @(posedge clock);
        #1 ctrl_start = 1'b0;
        wait_idle("busy_start_timeout", 400);
        repeat (200) @(negedge clock);
        check("busy_start_dones",  64'(dones - d0),  64'd1);
        check("busy_start_frames", 64'(frames - f0), 64'd1);
        check("busy_start_q_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back with start held high
        d0 = dones; f0 = frames;
        push_frame(32'h1234_5678);
        push_frame(32'h1234_5678);
        @(posedge clock);
        #1 data_in = 32'h1234_5678;
        ctrl_start = 1'b1;
        n = 0;
        while (frames < f0 + 2 && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("b2b_second_frame", 64'(frames - f0), 64'd2);
        @(posedge clock);
        #1 ctrl_start = 1'b0;
        wait_idle("b2b_timeout", 400);
        check("b2b_dones", 64'(dones - d0), 64'd2);
        check("b2b_gap", 64'(last_gap), 64'd1);
        if (done_cyc.size() >= 2)
            check("b2b_done_spacing", 64'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 64'd161);
        check("b2b_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame
        d0 = dones;
        push_frame(32'hCAFE_BABE);
        pulse_start(32'hCAFE_BABE, 32'h0);
        repeat (69) @(posedge clock);
        #2 ctrl_reset = 1'b1;
        #1;
        check("midrst_serial", {63'h0, serial_out}, 64'h1);
        check("midrst_busy",   {63'h0, ctrl_busy},  64'h0);
        check("midrst_done",   {63'h0, ctrl_done},  64'h0);
        repeat (3) @(posedge clock);
        #1 ctrl_reset = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clock);
        check("midrst_no_done", 64'(dones - d0), 64'd0);

        d0 = dones; f0 = frames;
        push_frame(32'hDEAD_BEEF);
        pulse_start(32'hDEAD_BEEF, 32'h0);
        wait_idle("post_rst_timeout", 400);
        check("post_rst_dones",  64'(dones - d0),  64'd1);
        check("post_rst_frames", 64'(frames - f0), 64'd1);
        check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
